// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit integer divider (DIV, DIVU, REM, REMU).
// Restoring radix-2 datapath, one quotient bit per cycle, IDLE/RUN/DONE FSM.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and the signed
// overflow case finish straight from IDLE to DONE instead of running 32 steps.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [31:0] dvd_r;      // dividend magnitude, shifts out as quotient shifts in
  logic [31:0] dsr_r;      // divisor magnitude
  logic [31:0] rem_r;      // partial remainder
  logic        sel_rem_r;  // 1: result is the remainder
  logic        neg_q_r;
  logic        neg_r_r;
  logic        div0_r;
  logic [31:0] result_r;
  logic        valid_r;

  logic        sgn_s;
  logic        div0_in_s;
  logic        ovf_in_s;
  logic        early_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] early_res_s;
  logic [32:0] rem_sh_s;
  logic        ge_s;
  logic [31:0] rem_nx_s;
  logic [31:0] dvd_nx_s;
  logic [31:0] q_fin_s;
  logic [31:0] r_fin_s;
  logic [31:0] final_s;

  // Request decode: operand magnitudes and special-case detection at capture time
  always_comb begin
    sgn_s       = ~op_i[0];
    div0_in_s   = (rs2_i == 32'd0);
    ovf_in_s    = sgn_s && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
    a_mag_s     = (sgn_s && rs1_i[31]) ? (32'd0 - rs1_i) : rs1_i;
    b_mag_s     = (sgn_s && rs2_i[31]) ? (32'd0 - rs2_i) : rs2_i;
    if (op_i[1]) begin
      early_res_s = div0_in_s ? rs1_i : 32'd0;
    end else begin
      early_res_s = div0_in_s ? 32'hFFFF_FFFF : 32'h8000_0000;
    end
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_s = div0_in_s | ovf_in_s;
`else
  assign early_s = 1'b0;
`endif

  // One restoring step plus sign fix-up of the would-be final result
  always_comb begin
    rem_sh_s = {rem_r, dvd_r[31]};
    ge_s     = (rem_sh_s >= {1'b0, dsr_r});
    if (ge_s) begin
      rem_nx_s = rem_sh_s[31:0] - dsr_r;
    end else begin
      rem_nx_s = rem_sh_s[31:0];
    end
    dvd_nx_s = {dvd_r[30:0], ge_s};
    // A zero divisor always yields all-ones, regardless of operand signs
    if (div0_r) begin
      q_fin_s = 32'hFFFF_FFFF;
    end else if (neg_q_r) begin
      q_fin_s = 32'd0 - dvd_nx_s;
    end else begin
      q_fin_s = dvd_nx_s;
    end
    r_fin_s = neg_r_r ? (32'd0 - rem_nx_s) : rem_nx_s;
    final_s = sel_rem_r ? r_fin_s : q_fin_s;
  end

  // Control FSM with datapath registers and registered result/valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= 5'd0;
      dvd_r     <= 32'd0;
      dsr_r     <= 32'd0;
      rem_r     <= 32'd0;
      sel_rem_r <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      div0_r    <= 1'b0;
      result_r  <= 32'd0;
      valid_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          valid_r <= 1'b0;
          if (start_i) begin
            dvd_r     <= a_mag_s;
            dsr_r     <= b_mag_s;
            rem_r     <= 32'd0;
            sel_rem_r <= op_i[1];
            neg_q_r   <= sgn_s & (rs1_i[31] ^ rs2_i[31]);
            neg_r_r   <= sgn_s & rs1_i[31];
            div0_r    <= div0_in_s;
            if (early_s) begin
              result_r <= early_res_s;
              valid_r  <= 1'b1;
              cnt_r    <= 5'd0;
              state_r  <= S_DONE;
            end else begin
              cnt_r   <= 5'd31;
              state_r <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_r <= rem_nx_s;
          dvd_r <= dvd_nx_s;
          if (cnt_r == 5'd0) begin
            result_r <= final_s;
            valid_r  <= 1'b1;
            state_r  <= S_DONE;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        S_DONE: begin
          // start_i still belongs to the instruction just completed
          valid_r <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          cnt_r   <= 5'd0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the same cycle the request appears
  assign busy_o   = ((state_r == S_IDLE) && start_i) || (state_r == S_RUN);
  assign valid_o  = valid_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (EARLY_EN && special) ? 1 : 33;
  endfunction

  // Drive a request in cycle N, push its expected result, return at the accepting edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    #1;
    check("busy_start", 32'(busy_o), 32'd1);
    sb_q.push_back(exp);
    @(posedge clk);
  endtask

  // Wait (bounded) for valid_o, check latency, stall, result and pulse width
  task automatic wait_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int          k;
    logic        bad;
    logic [31:0] exp;
    k = 0; bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1 && !hold) begin
        start_i = 1'b0;
        rs1_i = $urandom; rs2_i = $urandom; op_i = 2'($urandom);
      end
      if (valid_o) begin
        k = i;
        break;
      end else if (busy_o !== 1'b1) begin
        bad = 1'b1;
      end
    end
    check("latency", 32'(k), 32'(exp_lat(op, a, b)));
    check("busy_run", {31'd0, bad}, 32'd0);
    check("busy_done", 32'(busy_o), 32'd0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    check("result", result_o, exp);
    @(negedge clk);
    check("valid_pulse", 32'(valid_o), 32'd0);
    check("result_hold", result_o, exp);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b, exp);
    wait_result(op, a, b, 1'b0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0; start_i = 1'b0; op_i = 2'b00; rs1_i = 32'd0; rs2_i = 32'd0;
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(2'b01, 32'd100, 32'd7, 32'h0000_000E);
    run(2'b11, 32'd100, 32'd7, 32'h0000_0002);
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run(2'b10, 32'd5, 32'd0, 32'h0000_0005);
    run(2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);

    // Reset in the middle of RUN, then a normal operation
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; rs1_i = 32'd1000; rs2_i = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2'b01, 32'd9, 32'd3, 32'd3);

    // start_i held through DONE, second request accepted in the following IDLE
    issue(2'b01, 32'd50, 32'd5, 32'd10);
    wait_result(2'b01, 32'd50, 32'd5, 1'b1);
    check("b2b_accept", 32'(busy_o), 32'd1);
    sb_q.push_back(32'd10);
    @(posedge clk);
    wait_result(2'b01, 32'd50, 32'd5, 1'b0);

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 4 == 1) ra = 32'h0 - ra;
      run(rop, ra, rb, model(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
